// File: rtl/secure_pkg.sv
// Shared definitions for the secure register access path: FSM states,
// the privileged thread ID and default widths.
package secure_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int PRIV_TID           = 0;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TID_WIDTH      = 4;
    localparam int DEF_CNT_WIDTH      = 8;
    localparam int DEF_LOCK_THRESHOLD = 4;

endpackage

// File: rtl/secure_access_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and
// secure_access_ctrl (slave).
interface secure_access_ctrl_if
    import secure_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TID_WIDTH  = DEF_TID_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [TID_WIDTH-1:0]  req_thread_id;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_thread_id, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_thread_id, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/viol_counter.sv
// Saturating count of denied requests with a sticky lockout flag that
// latches on the edge the count reaches LOCK_THRESHOLD.
module viol_counter
    import secure_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int LOCK_THRESHOLD = DEF_LOCK_THRESHOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 lockout
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_THRESH = CNT_WIDTH'(LOCK_THRESHOLD);

    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] next_count_s;
    logic                 lockout_r;

    // Next count value: increment unless already saturated.
    always_comb begin
        next_count_s = count_r;
        if (inc && (count_r != CNT_MAX)) begin
            next_count_s = count_r + CNT_WIDTH'(1);
        end else begin
            next_count_s = count_r;
        end
    end

    // Count and sticky lockout registers; only rst_n clears lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= {CNT_WIDTH{1'b0}};
            lockout_r <= 1'b0;
        end else begin
            count_r <= next_count_s;
            if (inc && (next_count_s == CNT_THRESH)) begin
                lockout_r <= 1'b1;
            end else begin
                lockout_r <= lockout_r;
            end
        end
    end

    assign count   = count_r;
    assign lockout = lockout_r;
endmodule

// File: rtl/secure_access_ctrl.sv
// Front-end for secure_register: only the privileged thread reaches the
// register; denied requests are answered with an error and counted.
module secure_access_ctrl
    import secure_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TID_WIDTH      = DEF_TID_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int LOCK_THRESHOLD = DEF_LOCK_THRESHOLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    secure_access_ctrl_if.slave   bus,
    output logic                  reg_wr_en,
    output logic                  reg_access_en,
    output logic [DATA_WIDTH-1:0] reg_data_in,
    input  logic [DATA_WIDTH-1:0] reg_data_out,
    output logic [CNT_WIDTH-1:0]  viol_count,
    output logic                  lockout
);
    state_t                state_r;
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  wr_en_r;
    logic                  access_en_r;
    logic [DATA_WIDTH-1:0] data_in_r;
    logic                  write_r;
    logic                  lockout_s;
    logic                  accept_s;
    logic                  allowed_s;
    logic                  deny_s;

    assign accept_s  = bus.req_valid && (state_r == ST_IDLE);
    assign allowed_s = (bus.req_thread_id == TID_WIDTH'(PRIV_TID)) && !lockout_s;
    assign deny_s    = accept_s && !allowed_s;

    viol_counter #(
        .CNT_WIDTH      (CNT_WIDTH),
        .LOCK_THRESHOLD (LOCK_THRESHOLD)
    ) u_viol_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (deny_s),
        .count   (viol_count),
        .lockout (lockout_s)
    );

    // Request FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            wr_en_r     <= 1'b0;
            access_en_r <= 1'b0;
            data_in_r   <= {DATA_WIDTH{1'b0}};
            write_r     <= 1'b0;
        end else begin
            unique case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_r     <= bus.req_write;
                        req_ready_r <= 1'b0;
                        if (allowed_s) begin
                            state_r     <= ST_ACCESS;
                            access_en_r <= 1'b1;
                            wr_en_r     <= bus.req_write;
                            data_in_r   <= bus.req_wdata;
                        end else begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state_r     <= ST_WAIT;
                    access_en_r <= 1'b0;
                    wr_en_r     <= 1'b0;
                    data_in_r   <= {DATA_WIDTH{1'b0}};
                end
                ST_WAIT: begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= write_r ? {DATA_WIDTH{1'b0}} : reg_data_out;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= {DATA_WIDTH{1'b0}};
                    wr_en_r     <= 1'b0;
                    access_en_r <= 1'b0;
                    data_in_r   <= {DATA_WIDTH{1'b0}};
                    write_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign reg_wr_en     = wr_en_r;
    assign reg_access_en = access_en_r;
    assign reg_data_in   = data_in_r;
    assign lockout       = lockout_s;
endmodule

// File: tb/tb_secure_access_ctrl.sv
// Bench for secure_access_ctrl: vector table plus hand sequences for
// backpressure, asynchronous reset and counter saturation.
module tb_secure_access_ctrl;

    logic clk;
    logic rst_n;

    secure_access_ctrl_if #(.DATA_WIDTH(32), .TID_WIDTH(4)) a_if ();
    secure_access_ctrl_if #(.DATA_WIDTH(32), .TID_WIDTH(4)) b_if ();

    logic        a_wr_en, a_access_en;
    logic [31:0] a_data_in, a_data_out;
    logic [7:0]  a_viol;
    logic        a_lock;

    logic        b_wr_en, b_access_en;
    logic [31:0] b_data_in, b_data_out;
    logic [1:0]  b_viol;
    logic        b_lock;

    secure_access_ctrl u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (a_if),
        .reg_wr_en     (a_wr_en),
        .reg_access_en (a_access_en),
        .reg_data_in   (a_data_in),
        .reg_data_out  (a_data_out),
        .viol_count    (a_viol),
        .lockout       (a_lock)
    );

    secure_access_ctrl #(.CNT_WIDTH(2), .LOCK_THRESHOLD(3)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (b_if),
        .reg_wr_en     (b_wr_en),
        .reg_access_en (b_access_en),
        .reg_data_in   (b_data_in),
        .reg_data_out  (b_data_out),
        .viol_count    (b_viol),
        .lockout       (b_lock)
    );

    // Behavioural stand-in for secure_register.
    logic [31:0] reg_mem;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_mem    <= 32'h0;
            a_data_out <= 32'h0;
        end else if (a_access_en) begin
            if (a_wr_en) reg_mem <= a_data_in;
            a_data_out <= reg_mem;
        end
    end
    assign b_data_out = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [3:0]  tid;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_viol;
        bit          exp_lock;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 64'(a_if.req_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(a_if.rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(a_if.rsp_rdata), 64'd0);
        check({tag, "_rsp_err"},   64'(a_if.rsp_err),   64'd0);
        check({tag, "_wr_en"},     64'(a_wr_en),        64'd0);
        check({tag, "_access_en"}, 64'(a_access_en),    64'd0);
        check({tag, "_data_in"},   64'(a_data_in),      64'd0);
        check({tag, "_viol"},      64'(a_viol),         64'd0);
        check({tag, "_lockout"},   64'(a_lock),         64'd0);
    endtask

    // One full request on DUT A; hold>0 keeps rsp_ready low that many cycles.
    task automatic run_txn(input vec_t v, input int hold);
        int   lat;
        int   strobes;
        int   guard;
        int   exp_lat;
        rsp_t exp;
        exp_lat = v.exp_err ? 1 : 3;
        @(negedge clk);
        a_if.req_valid     = 1'b1;
        a_if.req_write     = v.wr;
        a_if.req_thread_id = v.tid;
        a_if.req_wdata     = v.wdata;
        a_if.rsp_ready     = (hold == 0);
        guard = 0;
        while (!a_if.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(a_if.req_ready), 64'd1);
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(negedge clk);
        a_if.req_valid = 1'b0;
        check("viol_count", 64'(a_viol), 64'(v.exp_viol));
        check("lockout", 64'(a_lock), 64'(v.exp_lock));
        check("busy_ready", 64'(a_if.req_ready), 64'd0);
        lat = 1;
        strobes = 0;
        while (!a_if.rsp_valid && lat < 12) begin
            if (a_access_en) begin
                strobes++;
                check("strobe_wr_en", 64'(a_wr_en), 64'(v.wr));
                check("strobe_data_in", 64'(a_data_in), 64'(v.wdata));
            end else begin
                check("idle_data_in", 64'(a_data_in), 64'd0);
            end
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 64'(lat), 64'(exp_lat));
        check("strobe_cycles", 64'(strobes), v.exp_err ? 64'd0 : 64'd1);
        check("rsp_access_en_low", 64'(a_access_en), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(a_if.rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(a_if.rsp_rdata), 64'(v.exp_rdata));
            check("bp_req_ready", 64'(a_if.req_ready), 64'd0);
        end
        a_if.rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check("rsp_rdata", 64'(a_if.rsp_rdata), 64'(exp.rdata));
            check("rsp_err", 64'(a_if.rsp_err), 64'(exp.err));
        end
        @(negedge clk);
        check("post_rsp_valid", 64'(a_if.rsp_valid), 64'd0);
        check("post_req_ready", 64'(a_if.req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        vec_t bp;
        int   exp_cnt;
        int   guard;
        vecs[0]  = '{1'b1, 4'd0,  32'hDEADBEEF, 1'b0, 32'h0,        8'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  32'h11111111, 1'b0, 32'hDEADBEEF, 8'd0, 1'b0};
        vecs[2]  = '{1'b1, 4'd5,  32'h12345678, 1'b1, 32'h0,        8'd1, 1'b0};
        vecs[3]  = '{1'b0, 4'd0,  32'h22222222, 1'b0, 32'hDEADBEEF, 8'd1, 1'b0};
        vecs[4]  = '{1'b1, 4'd0,  32'h000000A5, 1'b0, 32'h0,        8'd1, 1'b0};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h000000A5, 8'd1, 1'b0};
        vecs[6]  = '{1'b0, 4'd15, 32'h0,        1'b1, 32'h0,        8'd2, 1'b0};
        vecs[7]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 1'b1, 32'h0,        8'd3, 1'b0};
        vecs[8]  = '{1'b1, 4'd3,  32'h0,        1'b1, 32'h0,        8'd4, 1'b1};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b1, 32'h0,        8'd5, 1'b1};
        vecs[10] = '{1'b1, 4'd0,  32'h13579BDF, 1'b1, 32'h0,        8'd6, 1'b1};

        rst_n = 1'b0;
        a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_thread_id = 4'd0;
        a_if.req_wdata = 32'h0; a_if.rsp_ready = 1'b1;
        b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_thread_id = 4'd0;
        b_if.req_wdata = 32'h0; b_if.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i], 0);
        end

        // Lockout survives idle time and is cleared by reset only.
        repeat (3) @(negedge clk);
        check("lock_sticky", 64'(a_lock), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("rst2");

        // Backpressure on a thread-0 read.
        bp = '{1'b1, 4'd0, 32'h5A5A1234, 1'b0, 32'h0, 8'd0, 1'b0};
        run_txn(bp, 0);
        bp = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h5A5A1234, 8'd0, 1'b0};
        run_txn(bp, 10);

        // Asynchronous reset while the strobes are up.
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_write = 1'b1;
        a_if.req_thread_id = 4'd0; a_if.req_wdata = 32'h0BADF00D;
        @(negedge clk);
        a_if.req_valid = 1'b0;
        check("mid_access_en_up", 64'(a_access_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_access_en_drop", 64'(a_access_en), 64'd0);
        check("mid_wr_en_drop", 64'(a_wr_en), 64'd0);
        check("mid_data_in_drop", 64'(a_data_in), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("rst3");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale_rsp", 64'(a_if.rsp_valid), 64'd0);
        end

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            guard = 0;
            while (!b_if.req_ready && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            b_if.req_valid = 1'b1; b_if.req_write = 1'b1;
            b_if.req_thread_id = 4'd3; b_if.req_wdata = 32'(i + 1);
            @(negedge clk);
            b_if.req_valid = 1'b0;
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            check("sat_count", 64'(b_viol), 64'(exp_cnt));
            check("sat_lockout", 64'(b_lock), (i >= 2) ? 64'd1 : 64'd0);
            check("sat_rsp_valid", 64'(b_if.rsp_valid), 64'd1);
            check("sat_rsp_err", 64'(b_if.rsp_err), 64'd1);
            check("sat_rsp_rdata", 64'(b_if.rsp_rdata), 64'd0);
            check("sat_no_strobe", 64'({b_access_en, b_wr_en}), 64'd0);
            check("sat_data_in", 64'(b_data_in), 64'd0);
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
